// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode constants: HALT opcode, opcode field geometry, PC step.
package fetch_queue_pkg;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] HALT_OPCODE = 4'hF;

  // Byte distance between consecutive instructions.
  function automatic int pc_step(input int instr_w);
    return instr_w / 8;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; read data is the head entry.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr, w_rd;

  assign w_rd    = i_rd && (r_count != '0);
  assign w_wr    = i_wr && ((r_count != CNT_W'(DEPTH)) || w_rd);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr && !i_flush) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order issue to a latency-tolerant imem,
// prefetch queue of {pc, instr}, redirect flush and HALT stop.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OP_W-1:0]   HALT_OP  = HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               hlt
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(pc_step(INSTR_W));

  logic [ADDR_W-1:0]         r_fetch_pc;
  logic [CNT_W-1:0]          r_out, r_drop;
  logic                      r_halted;

  logic [CNT_W-1:0]          w_q_count, w_tag_count, w_out_next;
  logic [ADDR_W+INSTR_W-1:0] w_q_data;
  logic [ADDR_W-1:0]         w_tag_pc;
  logic [SUM_W-1:0]          w_busy;
  logic                      w_issue, w_enq, w_deq, w_is_halt, w_q_nonempty;

  assign w_busy    = SUM_W'(w_q_count) + SUM_W'(r_out);
  assign imem_req  = rst_n && !r_halted && !redirect && (w_busy < SUM_W'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_gnt;

  assign w_enq      = imem_rvalid && !redirect && (r_drop == '0);
  assign w_is_halt  = (imem_rdata[INSTR_W-1 -: OP_W] == HALT_OP);
  assign w_out_next = r_out + CNT_W'(w_issue) - CNT_W'(imem_rvalid);

  assign w_q_nonempty = (w_q_count != '0);
  assign out_valid    = w_q_nonempty && !redirect;
  assign w_deq        = out_valid && out_ready;
  assign out_pc       = w_q_nonempty ? w_q_data[ADDR_W+INSTR_W-1 -: ADDR_W] : '0;
  assign out_instr    = w_q_nonempty ? w_q_data[INSTR_W-1:0] : '0;
  assign hlt          = r_halted && !w_q_nonempty;

  // In-flight PC tags. Tags behind a HALT are discarded with the flush, so
  // only responses that are actually enqueued pop a tag.
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_issue),
    .i_wdata (r_fetch_pc),
    .i_rd    (w_enq),
    .i_flush (redirect || (w_enq && w_is_halt)),
    .o_rdata (w_tag_pc),
    .o_count (w_tag_count)
  );

  fetch_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_inst_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_enq),
    .i_wdata ({w_tag_pc, imem_rdata}),
    .i_rd    (w_deq),
    .i_flush (redirect),
    .o_rdata (w_q_data),
    .o_count (w_q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
      r_halted   <= 1'b0;
    end else if (redirect) begin
      // No issue this cycle; everything still outstanding becomes stale.
      r_fetch_pc <= redirect_pc;
      r_out      <= w_out_next;
      r_drop     <= w_out_next;
      r_halted   <= 1'b0;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + STEP;
      r_out <= w_out_next;
      if (w_enq && w_is_halt) begin
        r_halted <= 1'b1;
        r_drop   <= w_out_next;
      end else if (imem_rvalid && (r_drop != '0)) begin
        r_drop <= r_drop - 1'b1;
      end
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_out != '0));
  a_tags_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    w_tag_count <= r_out);
endmodule
